// File: rtl/reg_read_scoreboard_pkg.sv
// Shared sizing and constants for the ID-stage register read scoreboard.
// Data width and register count must match the register file.
package reg_read_scoreboard_pkg;

    localparam int WORD_LEN   = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 2;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/reg_read_scoreboard_pending_counter.sv
// Per-register count of in-flight writers: saturating up/down counter
// with synchronous clear. A decrement at zero is ignored.
module pending_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             pending,
    output logic             at_max
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             dec_eff;
    logic             inc_eff;

    // An increment at max is only allowed when a retire cancels it out.
    always_comb begin
        dec_eff  = dec && (cnt_reg != '0);
        inc_eff  = inc && ((cnt_reg != CNT_MAX) || dec_eff);
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc_eff && !dec_eff) begin
            cnt_next = cnt_reg + CNT_ONE;
        end else if (dec_eff && !inc_eff) begin
            cnt_next = cnt_reg - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt     = cnt_reg;
    assign pending = (cnt_reg != '0);
    assign at_max  = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/reg_read_scoreboard.sv
// ID-stage read scoreboard: stalls on pending sources, bypasses same-cycle
// writeback data and captures resolved operands into the ID/EX register.
module reg_read_scoreboard
    import reg_read_scoreboard_pkg::*;
#(
    parameter int WORD_LEN = reg_read_scoreboard_pkg::WORD_LEN,
    parameter int NUM_REGS = reg_read_scoreboard_pkg::NUM_REGS,
    parameter int CNT_W    = reg_read_scoreboard_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] rs_add,
    input  logic [REG_ADDR_W-1:0] rt_add,
    input  logic                  uses_rs,
    input  logic                  uses_rt,
    input  logic [REG_ADDR_W-1:0] dest_add,
    input  logic                  dest_we,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_add,
    input  logic [WORD_LEN-1:0]   wb_data,
    output logic [REG_ADDR_W-1:0] rf_r1_add,
    output logic [REG_ADDR_W-1:0] rf_r2_add,
    input  logic [WORD_LEN-1:0]   rf_r1,
    input  logic [WORD_LEN-1:0]   rf_r2,
    output logic                  stall,
    output logic                  ex_valid,
    output logic [WORD_LEN-1:0]   ex_rs_val,
    output logic [WORD_LEN-1:0]   ex_rt_val,
    output logic [REG_ADDR_W-1:0] ex_dest_add,
    output logic                  ex_dest_we,
    output logic                  wb_err
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]    cnt_arr [NUM_REGS];
    logic [NUM_REGS-1:0] pending_vec;
    logic [NUM_REGS-1:0] at_max_vec;

    logic                issue;
    logic                rs_hazard;
    logic                rt_hazard;
    logic                sat_hazard;
    logic [WORD_LEN-1:0] rs_val;
    logic [WORD_LEN-1:0] rt_val;

    logic                  ex_valid_reg;
    logic [WORD_LEN-1:0]   ex_rs_val_reg;
    logic [WORD_LEN-1:0]   ex_rt_val_reg;
    logic [REG_ADDR_W-1:0] ex_dest_add_reg;
    logic                  ex_dest_we_reg;
    logic                  wb_err_reg;

    // Register 0 has no counter: it is never pending and never saturates.
    assign cnt_arr[0]     = '0;
    assign pending_vec[0] = 1'b0;
    assign at_max_vec[0]  = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
            logic inc;
            logic dec;
            assign inc = issue && dest_we && (dest_add == REG_ADDR_W'(gi));
            assign dec = wb_we && !flush && (wb_add == REG_ADDR_W'(gi));

            pending_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk     (clk),
                .rst     (rst),
                .clr     (flush),
                .inc     (inc),
                .dec     (dec),
                .cnt     (cnt_arr[gi]),
                .pending (pending_vec[gi]),
                .at_max  (at_max_vec[gi])
            );
        end
    endgenerate

    function automatic logic [WORD_LEN-1:0] sel_operand(
        input logic [REG_ADDR_W-1:0] addr,
        input logic [WORD_LEN-1:0]   rf_data
    );
        if (addr == ZERO_REG) begin
            return '0;
        end else if (wb_we && (wb_add == addr)) begin
            return wb_data;
        end
        return rf_data;
    endfunction

    // A source whose last outstanding writer retires this cycle is served by bypass.
    always_comb begin
        rs_hazard  = uses_rs && pending_vec[rs_add] &&
                     !(wb_we && (wb_add == rs_add) && (cnt_arr[rs_add] == CNT_ONE));
        rt_hazard  = uses_rt && pending_vec[rt_add] &&
                     !(wb_we && (wb_add == rt_add) && (cnt_arr[rt_add] == CNT_ONE));
        sat_hazard = dest_we && at_max_vec[dest_add] && !(wb_we && (wb_add == dest_add));
        stall      = !rst && id_valid && !flush && (rs_hazard || rt_hazard || sat_hazard);
        issue      = id_valid && !stall && !flush;
        rs_val     = sel_operand(rs_add, rf_r1);
        rt_val     = sel_operand(rt_add, rf_r2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_reg    <= 1'b0;
            ex_rs_val_reg   <= '0;
            ex_rt_val_reg   <= '0;
            ex_dest_add_reg <= '0;
            ex_dest_we_reg  <= 1'b0;
            wb_err_reg      <= 1'b0;
        end else begin
            ex_valid_reg <= issue;
            if (issue) begin
                ex_rs_val_reg   <= rs_val;
                ex_rt_val_reg   <= rt_val;
                ex_dest_add_reg <= dest_add;
                ex_dest_we_reg  <= dest_we;
            end
            // Writes to register 0 are legal discards, not orphan writebacks.
            wb_err_reg <= wb_we && !flush && (wb_add != ZERO_REG) && !pending_vec[wb_add];
        end
    end

    assign rf_r1_add   = rs_add;
    assign rf_r2_add   = rt_add;
    assign ex_valid    = ex_valid_reg;
    assign ex_rs_val   = ex_rs_val_reg;
    assign ex_rt_val   = ex_rt_val_reg;
    assign ex_dest_add = ex_dest_add_reg;
    assign ex_dest_we  = ex_dest_we_reg;
    assign wb_err      = wb_err_reg;

endmodule

// File: tb/tb_reg_read_scoreboard.sv
// Directed bench for reg_read_scoreboard; expected EX contents are queued
// when an issue is driven and compared when the EX register loads.
module tb_reg_read_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        id_valid;
    logic [4:0]  rs_add;
    logic [4:0]  rt_add;
    logic        uses_rs;
    logic        uses_rt;
    logic [4:0]  dest_add;
    logic        dest_we;
    logic        wb_we;
    logic [4:0]  wb_add;
    logic [31:0] wb_data;
    logic [4:0]  rf_r1_add;
    logic [4:0]  rf_r2_add;
    logic [31:0] rf_r1;
    logic [31:0] rf_r2;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_rs_val;
    logic [31:0] ex_rt_val;
    logic [4:0]  ex_dest_add;
    logic        ex_dest_we;
    logic        wb_err;

    typedef struct {
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [4:0]  dest;
        logic        we;
    } ex_t;

    ex_t exp_q[$];
    int  n_pass  = 0;
    int  n_total = 0;

    reg_read_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .id_valid    (id_valid),
        .rs_add      (rs_add),
        .rt_add      (rt_add),
        .uses_rs     (uses_rs),
        .uses_rt     (uses_rt),
        .dest_add    (dest_add),
        .dest_we     (dest_we),
        .wb_we       (wb_we),
        .wb_add      (wb_add),
        .wb_data     (wb_data),
        .rf_r1_add   (rf_r1_add),
        .rf_r2_add   (rf_r2_add),
        .rf_r1       (rf_r1),
        .rf_r2       (rf_r2),
        .stall       (stall),
        .ex_valid    (ex_valid),
        .ex_rs_val   (ex_rs_val),
        .ex_rt_val   (ex_rt_val),
        .ex_dest_add (ex_dest_add),
        .ex_dest_we  (ex_dest_we),
        .wb_err      (wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush    = 1'b0;
        id_valid = 1'b0;
        rs_add   = '0;
        rt_add   = '0;
        uses_rs  = 1'b0;
        uses_rt  = 1'b0;
        dest_add = '0;
        dest_we  = 1'b0;
        wb_we    = 1'b0;
        wb_add   = '0;
        wb_data  = '0;
    endtask

    task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic [4:0] dest, input logic dwe);
        id_valid = 1'b1;
        rs_add   = rs;
        rt_add   = rt;
        uses_rs  = urs;
        uses_rt  = urt;
        dest_add = dest;
        dest_we  = dwe;
    endtask

    task automatic wb(input logic [4:0] add, input logic [31:0] data);
        wb_we   = 1'b1;
        wb_add  = add;
        wb_data = data;
    endtask

    task automatic push(input logic [31:0] rsv, input logic [31:0] rtv,
                        input logic [4:0] dest, input logic we);
        ex_t e;
        e.rs_val = rsv;
        e.rt_val = rtv;
        e.dest   = dest;
        e.we     = we;
        exp_q.push_back(e);
    endtask

    task automatic pop_ex(input string tag);
        ex_t e;
        if (exp_q.size() == 0) begin
            n_total++;
            $error("FAIL %s: observed empty scoreboard expected queued entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".valid"}, 32'(ex_valid), 32'd1);
            chk({tag, ".rs"}, ex_rs_val, e.rs_val);
            chk({tag, ".rt"}, ex_rt_val, e.rt_val);
            chk({tag, ".dest"}, 32'(ex_dest_add), 32'(e.dest));
            chk({tag, ".we"}, 32'(ex_dest_we), 32'(e.we));
        end
    endtask

    initial begin
        idle();
        rf_r1 = '0;
        rf_r2 = '0;
        rst   = 1'b1;
        tick();
        tick();
        chk("reset.stall", 32'(stall), 32'd0);
        chk("reset.ex_valid", 32'(ex_valid), 32'd0);
        chk("reset.ex_rs_val", ex_rs_val, 32'd0);
        chk("reset.wb_err", 32'(wb_err), 32'd0);
        rst = 1'b0;
        tick();

        // 1: plain issue, operands from the register file
        instr(5'd3, 5'd4, 1'b1, 1'b1, 5'd11, 1'b0);
        rf_r1 = 32'd10;
        rf_r2 = 32'd20;
        #1;
        chk("t1.stall", 32'(stall), 32'd0);
        chk("t1.rf_r1_add", 32'(rf_r1_add), 32'd3);
        chk("t1.rf_r2_add", 32'(rf_r2_add), 32'd4);
        push(32'd10, 32'd20, 5'd11, 1'b0);
        tick();
        idle();
        pop_ex("t1.ex");
        tick();
        chk("t1.bubble", 32'(ex_valid), 32'd0);

        // 2: RAW on r5 until writeback, then bypass
        rf_r1 = 32'h11;
        rf_r2 = 32'h22;
        instr(5'd1, 5'd2, 1'b0, 1'b0, 5'd5, 1'b1);
        push(32'h11, 32'h22, 5'd5, 1'b1);
        tick();
        pop_ex("t2.writer");
        instr(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        #1;
        chk("t2.stall_c0", 32'(stall), 32'd1);
        tick();
        chk("t2.bubble", 32'(ex_valid), 32'd0);
        chk("t2.stall_c1", 32'(stall), 32'd1);
        wb(5'd5, 32'hDEAD_BEEF);
        #1;
        chk("t2.stall_wb", 32'(stall), 32'd0);
        push(32'hDEAD_BEEF, 32'd0, 5'd0, 1'b0);
        tick();
        idle();
        pop_ex("t2.bypass");

        // 3: two writers to r7; only the last retirement releases the reader
        instr(5'd1, 5'd2, 1'b0, 1'b0, 5'd7, 1'b1);
        push(32'h11, 32'h22, 5'd7, 1'b1);
        tick();
        pop_ex("t3.w1");
        push(32'h11, 32'h22, 5'd7, 1'b1);
        tick();
        pop_ex("t3.w2");
        instr(5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        #1;
        chk("t3.stall_pre", 32'(stall), 32'd1);
        wb(5'd7, 32'hAAAA_0001);
        #1;
        chk("t3.stall_wb1", 32'(stall), 32'd1);
        tick();
        chk("t3.bubble", 32'(ex_valid), 32'd0);
        wb(5'd7, 32'hBBBB_0002);
        #1;
        chk("t3.stall_wb2", 32'(stall), 32'd0);
        push(32'hBBBB_0002, 32'd0, 5'd0, 1'b0);
        tick();
        idle();
        pop_ex("t3.bypass");

        // 4: saturate r9 at three writers
        for (int i = 0; i < 3; i++) begin
            instr(5'd1, 5'd2, 1'b0, 1'b0, 5'd9, 1'b1);
            push(32'h11, 32'h22, 5'd9, 1'b1);
            tick();
            pop_ex("t4.fill");
        end
        #1;
        chk("t4.sat_stall", 32'(stall), 32'd1);
        tick();
        chk("t4.sat_bubble", 32'(ex_valid), 32'd0);
        wb(5'd9, 32'h9999_0000);
        #1;
        chk("t4.sat_wb_stall", 32'(stall), 32'd0);
        push(32'h11, 32'h22, 5'd9, 1'b1);
        tick();
        pop_ex("t4.sat_issue");
        wb_we = 1'b0;
        #1;
        chk("t4.still_full", 32'(stall), 32'd1);
        tick();
        idle();

        // 5: register 0 reads as zero despite rf and writeback data
        instr(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1);
        rf_r1 = 32'h55;
        rf_r2 = 32'h66;
        wb(5'd0, 32'h1234);
        #1;
        chk("t5.stall", 32'(stall), 32'd0);
        push(32'd0, 32'd0, 5'd0, 1'b1);
        tick();
        idle();
        pop_ex("t5.zero");
        instr(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
        #1;
        chk("t5.r0_not_pending", 32'(stall), 32'd0);
        push(32'd0, 32'd0, 5'd0, 1'b0);
        tick();
        idle();
        pop_ex("t5.zero2");

        // 6a: flush clears pending state and ignores a concurrent writeback
        rf_r1 = 32'h11;
        rf_r2 = 32'h22;
        instr(5'd1, 5'd2, 1'b0, 1'b0, 5'd2, 1'b1);
        push(32'h11, 32'h22, 5'd2, 1'b1);
        tick();
        pop_ex("t6.w2");
        instr(5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        flush = 1'b1;
        wb(5'd8, 32'h8888);
        #1;
        chk("t6.flush_stall", 32'(stall), 32'd0);
        tick();
        chk("t6.flush_bubble", 32'(ex_valid), 32'd0);
        chk("t6.flush_no_err", 32'(wb_err), 32'd0);
        idle();
        instr(5'd2, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0);
        rf_r1 = 32'h2222;
        rf_r2 = 32'h9999;
        #1;
        chk("t6.post_flush_stall", 32'(stall), 32'd0);
        push(32'h2222, 32'h9999, 5'd0, 1'b0);
        tick();
        idle();
        pop_ex("t6.post_flush");

        // 6b: writeback to an idle register
        wb(5'd8, 32'h8888);
        tick();
        idle();
        chk("t6.wb_err_pulse", 32'(wb_err), 32'd1);
        tick();
        chk("t6.wb_err_clear", 32'(wb_err), 32'd0);

        // 6c: asynchronous reset during a stall
        rf_r1 = 32'h11;
        rf_r2 = 32'h22;
        instr(5'd1, 5'd2, 1'b0, 1'b0, 5'd12, 1'b1);
        push(32'h11, 32'h22, 5'd12, 1'b1);
        tick();
        pop_ex("t6.w12");
        instr(5'd12, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        #1;
        chk("t6.pre_rst_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6.rst_stall", 32'(stall), 32'd0);
        chk("t6.rst_ex_valid", 32'(ex_valid), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6.post_rst_stall", 32'(stall), 32'd0);
        tick();
        idle();
        exp_q.delete();
        tick();
        chk("end.bubble", 32'(ex_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_read_scoreboard.md
Name: reg_read_scoreboard

Overview:
- Read-side companion to the register file in the MIPS pipeline.
- Sits in ID: tracks in-flight writes per register, stalls instructions whose source operands are pending, and bypasses same-cycle writeback data.
- Captures the resolved operands into the ID/EX boundary register.
- Drives the register file read addresses and consumes its asynchronous read data.

Parameters:
- WORD_LEN, 32, data word width (shared with register file).
- NUM_REGS, 32, architectural registers; address width is log2(NUM_REGS) = 5.
- CNT_W, 2, pending-writer counter width per register; max in-flight writers per register = 2^CNT_W - 1.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous pipeline flush.
- id_valid  in  1  instruction present in ID.
- rs_add  in  5  source 1 address.
- rt_add  in  5  source 2 address.
- uses_rs  in  1  instruction reads rs.
- uses_rt  in  1  instruction reads rt.
- dest_add  in  5  destination register.
- dest_we  in  1  instruction will write dest_add.
- wb_we  in  1  writeback strobe (same signal as the register file write_signal).
- wb_add  in  5  writeback address.
- wb_data  in  WORD_LEN  writeback data.
- rf_r1_add  out  5  register file read address 1; equals rs_add.
- rf_r2_add  out  5  register file read address 2; equals rt_add.
- rf_r1  in  WORD_LEN  register file read data 1.
- rf_r2  in  WORD_LEN  register file read data 2.
- stall  out  1  combinational; hold IF/ID.
- ex_valid  out  1  registered; operands valid in EX.
- ex_rs_val  out  WORD_LEN  registered operand 1.
- ex_rt_val  out  WORD_LEN  registered operand 2.
- ex_dest_add  out  5  registered destination address.
- ex_dest_we  out  1  registered destination write enable.
- wb_err  out  1  registered; one-cycle pulse on writeback to a register with count 0.

Behaviour:
- Reset:
  - All counters = 0.
  - ex_valid, ex_dest_we and wb_err = 0; ex_rs_val, ex_rt_val and ex_dest_add = 0.
  - stall = 0 while rst is asserted.
- Register 0:
  - Never pending; its counter is held at 0.
  - Reading it always yields 0, regardless of rf or wb data.
  - Issue or writeback targeting it does not change any counter.
- Pending: cnt[r] != 0.
- wb_clear(r) = wb_we && wb_add == r && cnt[r] == 1 (the last outstanding writer retires this cycle).
- Source hazard on rs: uses_rs && pending(rs) && !wb_clear(rs). Same rule applies to rt.
- Saturation hazard: dest_we && cnt[dest_add] == max && !(wb_we && wb_add == dest_add).
- stall = id_valid && !flush && (any source hazard || saturation hazard).
- Issue:
  - Issue = id_valid && !stall && !flush.
  - On issue, cnt[dest_add] += 1 if dest_we and dest_add != 0.
- Writeback:
  - On wb_we, cnt[wb_add] -= 1 when the count is > 0.
  - When the count is 0: no change, and wb_err = 1 next cycle.
- Simultaneous issue and writeback to the same register: net count unchanged.
- Operand select, priority order:
  1. Address 0 → 0.
  2. wb_we && wb_add == addr → wb_data (bypass).
  3. Otherwise rf data.
- EX register, posedge:
  - On issue: ex_valid = 1 and the operands/dest fields are loaded.
  - Otherwise: ex_valid = 0 (bubble), data fields hold.
  - Latency: ID to EX is 1 cycle.
- Flush, synchronous:
  - Clears all counters and sets ex_valid = 0; no issue occurs that cycle.
  - A writeback in the same cycle is ignored and does not raise wb_err.
- Reset mid-operation: asynchronous clear of all state; any in-flight write is forgotten.

Decomposition:
- Shared package/config header holds WORD_LEN, REG_ADDR_W = 5, NUM_REGS and the zero-register constant.
- One natural sub-module: pending_counter, a per-register CNT_W saturating up/down counter with inc, dec and clr inputs and pending/at_max outputs. It is instantiated NUM_REGS-1 times.

Test Plan:
1. Reset then issue ADD with rs=3, rt=4 (counts 0), rf_r1=10, rf_r2=20 → stall=0; next cycle ex_valid=1, ex_rs_val=10, ex_rt_val=20.
2. RAW stall and release:
   - Issue dest=5 with dest_we=1, then the next instruction reads rs=5 → stall=1 for each cycle until wb_we with wb_add=5.
   - In that writeback cycle stall=0, and the following cycle ex_rs_val = wb_data (e.g. 0xDEAD_BEEF).
3. Two writers to r7 (count reaches 2), reader of r7 → the first wb to r7 keeps stall=1; the second wb to r7 releases it with its data bypassed.
4. Saturation: issue 3 writers to r9 with no writeback, then a 4th writer to r9 → stall=1; a wb to r9 in that cycle → stall=0 and count stays 3.
5. rs=0, rt=0 with rf returning nonzero and wb_we to address 0 with 0x1234 → ex_rs_val = ex_rt_val = 0; no stall, no count change.
6. Flush and async reset:
   - With r2 pending, assert flush → next cycle ex_valid=0, and a reader of r2 is not stalled.
   - Separately, wb to an idle r8 → wb_err pulses for 1 cycle.
   - Asserting rst mid-stall drops stall immediately.
